// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown to 00:00 with done pulse and timed alarm; AUTO_RELOAD_EN enables reload of the last loaded value
module countdown_timer #(
  parameter int TICKS_PER_SEC = 4,
  parameter int ALARM_TICKS = 40
) (
  input  logic       clk4,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] set_0,
  input  logic [3:0] set_1,
  input  logic [3:0] set_2,
  input  logic [3:0] set_3,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] current_time_0,
  output logic [3:0] current_time_1,
  output logic [3:0] current_time_2,
  output logic [3:0] current_time_3,
  output logic       running,
  output logic       done,
  output logic       alarm
);
  localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = ALARM_TICKS > 1 ? $clog2(ALARM_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_n;
  logic [0:3][3:0] cur, cur_n, ld, dec;
  logic [TW-1:0] tick, tick_n;
  logic [AW-1:0] alarm_cnt, alarm_cnt_n;
  logic running_n, done_n, alarm_n, wrap;
`ifdef AUTO_RELOAD_EN
  logic [0:3][3:0] saved, saved_n;
`endif
  assign current_time_0 = cur[0];
  assign current_time_1 = cur[1];
  assign current_time_2 = cur[2];
  assign current_time_3 = cur[3];
  assign wrap = tick == TW'(TICKS_PER_SEC - 1);
  // clamp the incoming digits and form the one-second decrement with its borrow chain
  always_comb begin
    ld[0] = set_0 > 4'd5 ? 4'd5 : set_0;
    ld[1] = set_1 > 4'd9 ? 4'd9 : set_1;
    ld[2] = set_2 > 4'd5 ? 4'd5 : set_2;
    ld[3] = set_3 > 4'd9 ? 4'd9 : set_3;
    dec[3] = cur[3] == 4'd0 ? 4'd9 : cur[3] - 4'd1;
    dec[2] = cur[3] != 4'd0 ? cur[2] : (cur[2] == 4'd0 ? 4'd5 : cur[2] - 4'd1);
    dec[1] = (cur[3] != 4'd0 || cur[2] != 4'd0) ? cur[1] : (cur[1] == 4'd0 ? 4'd9 : cur[1] - 4'd1);
    dec[0] = (cur[3] != 4'd0 || cur[2] != 4'd0 || cur[1] != 4'd0) ? cur[0] : (cur[0] == 4'd0 ? 4'd5 : cur[0] - 4'd1);
  end
  // next-state logic in priority order clear > load > start > pause > counting
  always_comb begin
    state_n = state;
    cur_n = cur;
    tick_n = tick;
    done_n = 1'b0;
    alarm_n = alarm && alarm_cnt != '0;
    alarm_cnt_n = alarm_cnt == '0 ? '0 : alarm_cnt - AW'(1);
`ifdef AUTO_RELOAD_EN
    saved_n = saved;
`endif
    if (clear) begin
      state_n = IDLE;
      cur_n = '0;
      tick_n = '0;
      alarm_n = 1'b0;
      alarm_cnt_n = '0;
    end else if (load && state != RUN) begin
      state_n = state == DONE ? IDLE : state;
      cur_n = ld;
      tick_n = '0;
      alarm_n = 1'b0;
      alarm_cnt_n = '0;
`ifdef AUTO_RELOAD_EN
      saved_n = ld;
`endif
    end else if (start && state != RUN && cur != '0) begin
      state_n = RUN;
    end else if (pause && state == RUN) begin
      state_n = PAUSE;
    end else if (state == RUN) begin
      tick_n = wrap ? '0 : tick + TW'(1);
      if (wrap && cur != '0) begin
        cur_n = dec;
        if (dec == '0) begin
          done_n = 1'b1;
          alarm_n = 1'b1;
          alarm_cnt_n = AW'(ALARM_TICKS - 1);
`ifdef AUTO_RELOAD_EN
          cur_n = saved;
          state_n = saved == '0 ? IDLE : RUN;
`else
          state_n = DONE;
`endif
        end
      end
    end
    running_n = state_n == RUN;
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk4) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      tick <= '0;
      alarm_cnt <= '0;
      running <= 1'b0;
      done <= 1'b0;
      alarm <= 1'b0;
`ifdef AUTO_RELOAD_EN
      saved <= '0;
`endif
    end else begin
      state <= state_n;
      cur <= cur_n;
      tick <= tick_n;
      alarm_cnt <= alarm_cnt_n;
      running <= running_n;
      done <= done_n;
      alarm <= alarm_n;
`ifdef AUTO_RELOAD_EN
      saved <= saved_n;
`endif
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector table, corner sequences and randomized run against a seconds-based reference model
module tb_countdown_timer;
  localparam int TPS = 4;
  localparam int AT = 40;
`ifdef AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk4 = 1'b0;
  logic reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [3:0] set_0 = '0, set_1 = '0, set_2 = '0, set_3 = '0;
  logic [3:0] current_time_0, current_time_1, current_time_2, current_time_3;
  logic running, done, alarm;
  int errors = 0, checks = 0;
  int m_state, m_secs, m_tick, m_alarm, m_saved;
  bit m_done;

  typedef struct {
    logic [3:0]  ctl;
    logic [15:0] set;
    logic [15:0] t;
    logic [2:0]  rda;
  } vec_t;
  vec_t tbl[20];

  countdown_timer #(.TICKS_PER_SEC(TPS), .ALARM_TICKS(AT)) dut (
    .clk4(clk4), .reset(reset), .load(load),
    .set_0(set_0), .set_1(set_1), .set_2(set_2), .set_3(set_3),
    .start(start), .pause(pause), .clear(clear),
    .current_time_0(current_time_0), .current_time_1(current_time_1),
    .current_time_2(current_time_2), .current_time_3(current_time_3),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk4 = ~clk4;

  function automatic int clampi(int v, int lim);
    return v > lim ? lim : v;
  endfunction

  // model: time held as total seconds, states 0 idle 1 run 2 pause 3 done
  task automatic model_step();
    if (reset) begin
      m_state = 0; m_secs = 0; m_tick = 0; m_alarm = 0; m_saved = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_alarm > 0) m_alarm--;
      if (clear) begin
        m_state = 0; m_secs = 0; m_tick = 0; m_alarm = 0;
      end else if (load && m_state != 1) begin
        m_secs = clampi(int'(set_0), 5) * 600 + clampi(int'(set_1), 9) * 60 + clampi(int'(set_2), 5) * 10 + clampi(int'(set_3), 9);
        m_saved = m_secs; m_tick = 0; m_alarm = 0;
        if (m_state == 3) m_state = 0;
      end else if (start && m_state != 1 && m_secs != 0) begin
        m_state = 1;
      end else if (pause && m_state == 1) begin
        m_state = 2;
      end else if (m_state == 1) begin
        m_tick++;
        if (m_tick == TPS) begin
          m_tick = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_done = 1; m_alarm = AT;
            if (AR) begin
              m_secs = m_saved;
              m_state = m_saved != 0 ? 1 : 0;
            end else m_state = 3;
          end
        end
      end
    end
  endtask

  function automatic logic [18:0] m_vec();
    int mm, ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_state == 1, m_done, m_alarm > 0};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {current_time_0, current_time_1, current_time_2, current_time_3, running, done, alarm};
  endfunction

  function automatic logic [15:0] tm();
    return {current_time_0, current_time_1, current_time_2, current_time_3};
  endfunction

  task automatic cyc();
    @(posedge clk4);
    model_step();
    @(negedge clk4);
  endtask

  task automatic apply(input logic [3:0] ctl, input logic [15:0] s);
    {clear, load, start, pause} = ctl;
    {set_0, set_1, set_2, set_3} = s;
    cyc();
    {clear, load, start, pause} = 4'b0000;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n, a, seen;
    tbl[0]  = '{4'b0100, 16'h0105, 16'h0105, 3'b000};
    tbl[1]  = '{4'b0010, 16'h0000, 16'h0105, 3'b100};
    tbl[2]  = '{4'b0000, 16'h0000, 16'h0105, 3'b100};
    tbl[3]  = '{4'b0000, 16'h0000, 16'h0105, 3'b100};
    tbl[4]  = '{4'b0000, 16'h0000, 16'h0105, 3'b100};
    tbl[5]  = '{4'b0000, 16'h0000, 16'h0104, 3'b100};
    tbl[6]  = '{4'b0100, 16'h73CC, 16'h0104, 3'b100};
    tbl[7]  = '{4'b0001, 16'h0000, 16'h0104, 3'b000};
    tbl[8]  = '{4'b0100, 16'h739C, 16'h5359, 3'b000};
    tbl[9]  = '{4'b1000, 16'h0000, 16'h0000, 3'b000};
    tbl[10] = '{4'b0010, 16'h0000, 16'h0000, 3'b000};
    tbl[11] = '{4'b0100, 16'h0001, 16'h0001, 3'b000};
    tbl[12] = '{4'b0010, 16'h0000, 16'h0001, 3'b100};
    tbl[13] = '{4'b0000, 16'h0000, 16'h0001, 3'b100};
    tbl[14] = '{4'b0000, 16'h0000, 16'h0001, 3'b100};
    tbl[15] = '{4'b0000, 16'h0000, 16'h0001, 3'b100};
    tbl[16] = '{4'b0000, 16'h0000, AR ? 16'h0001 : 16'h0000, {AR, 2'b11}};
    tbl[17] = '{4'b0000, 16'h0000, AR ? 16'h0001 : 16'h0000, {AR, 2'b01}};
    tbl[18] = '{4'b0010, 16'h0000, AR ? 16'h0001 : 16'h0000, {AR, 2'b01}};
    tbl[19] = '{4'b0100, 16'h0010, AR ? 16'h0001 : 16'h0010, {AR, 1'b0, AR}};

    cyc();
    cyc();
    chk("reset state", 32'(dut_vec()), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].ctl, tbl[i].set);
      chk($sformatf("vec%0d time", i), 32'(tm()), 32'(tbl[i].t));
      chk($sformatf("vec%0d run/done/alarm", i), 32'({running, done, alarm}), 32'(tbl[i].rda));
    end

    apply(4'b1000, 16'h0);
    apply(4'b0100, 16'h0105);
    apply(4'b0010, 16'h0);
    repeat (20) apply(4'b0000, 16'h0);
    chk("01:05 after 20", 32'({tm(), running}), 32'({16'h0100, 1'b1}));

    apply(4'b1000, 16'h0);
    apply(4'b0100, 16'h0100);
    apply(4'b0010, 16'h0);
    repeat (4) apply(4'b0000, 16'h0);
    chk("01:00 borrow", 32'({tm(), running}), 32'({16'h0059, 1'b1}));

`ifndef AUTO_RELOAD_EN
    apply(4'b1000, 16'h0);
    apply(4'b0100, 16'h0001);
    apply(4'b0010, 16'h0);
    n = 0;
    while (!done && n < 20) begin
      apply(4'b0000, 16'h0);
      n++;
    end
    chk("cycles to done", n, 4);
    chk("done state", 32'({tm(), running, alarm}), 32'({16'h0000, 1'b0, 1'b1}));
    a = 1;
    apply(4'b0000, 16'h0);
    chk("done one cycle", 32'(done), 32'(1'b0));
    while (alarm && a < 100) begin
      a++;
      apply(4'b0000, 16'h0);
    end
    chk("alarm length", a, AT);
`endif

    apply(4'b1000, 16'h0);
    apply(4'b0100, 16'h0010);
    apply(4'b0010, 16'h0);
    repeat (2) apply(4'b0000, 16'h0);
    apply(4'b0001, 16'h0);
    for (int i = 0; i < 10; i++) begin
      apply(4'b0000, 16'h0);
      chk($sformatf("paused %0d", i), 32'({tm(), running}), 32'({16'h0010, 1'b0}));
    end
    apply(4'b0010, 16'h0);
    apply(4'b0000, 16'h0);
    chk("resume tick3", 32'({tm(), running}), 32'({16'h0010, 1'b1}));
    apply(4'b0000, 16'h0);
    chk("resume decrement", 32'({tm(), running}), 32'({16'h0009, 1'b1}));

    apply(4'b1000, 16'h0);
    apply(4'b0100, 16'h0003);
    apply(4'b0010, 16'h0);
    repeat (5) apply(4'b0000, 16'h0);
    apply(4'b1000, 16'h0);
    chk("clear mid-run", 32'(dut_vec()), 32'h0);
    seen = 0;
    repeat (16) begin
      apply(4'b0000, 16'h0);
      if (done) seen++;
    end
    chk("no done after clear", seen, 0);

    apply(4'b0100, 16'h0105);
    apply(4'b0010, 16'h0);
    repeat (2) apply(4'b0000, 16'h0);
    reset = 1'b1;
    apply(4'b0000, 16'h0);
    chk("reset mid-run", 32'(dut_vec()), 32'h0);
    reset = 1'b0;

`ifdef AUTO_RELOAD_EN
    apply(4'b0100, 16'h0002);
    apply(4'b0010, 16'h0);
    n = 0;
    while (!done && n < 20) begin
      apply(4'b0000, 16'h0);
      n++;
    end
    chk("reload cycles", n, 8);
    chk("reload value", 32'({tm(), running, alarm}), 32'({16'h0002, 1'b1, 1'b1}));
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(299) == 0;
      clear = $urandom_range(39) == 0;
      load = $urandom_range(7) == 0;
      start = $urandom_range(5) == 0;
      pause = $urandom_range(15) == 0;
      if ($urandom_range(9) == 0) begin
        set_0 = 4'($urandom); set_1 = 4'($urandom); set_2 = 4'($urandom); set_3 = 4'($urandom);
      end else begin
        set_0 = 4'd0;
        set_1 = 4'($urandom_range(1));
        set_2 = 4'($urandom_range(6));
        set_3 = 4'($urandom_range(11));
      end
      cyc();
      chk($sformatf("rand%0d", i), 32'(dut_vec()), 32'(m_vec()));
    end
    {reset, clear, load, start, pause} = 5'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
